// File: rtl/is61lv6416l_sram.sv
// is61lv6416l_sram: 16-bit asynchronous SRAM model in the IS61LV6416L style.
// Reads are combinational onto a shared tri-state bus with per-byte lane enables.
// Writes are committed on the rising clock edge so the model is cycle-exact in a
// clocked environment. The array is never cleared by reset, which keeps writes
// usable while the surrounding system is still held in reset (firmware preload).

module is61lv6416l_sram #(
    parameter int unsigned memdepth = 65536,
    parameter int unsigned addbits  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [addbits-1:0] A,
    inout  logic [15:0]        IO,
    input  logic               CE_,
    input  logic               OE_,
    input  logic               WE_,
    input  logic               LB_,
    input  logic               UB_
);

    // Width of the array index; at least one bit even for a single-word array.
    localparam int unsigned IdxBits = (memdepth > 1) ? $clog2(memdepth) : 1;
    // Range compare is done wide enough for both the address and the depth.
    localparam int unsigned CmpBits = (addbits > 32) ? addbits + 1 : 33;
    localparam logic [CmpBits-1:0] DepthExt = CmpBits'(memdepth);

    logic [15:0]        mem [memdepth] = '{default: 16'h0000};

    logic [CmpBits-1:0] a_ext;
    logic               in_range;
    logic [IdxBits-1:0] idx;
    logic               wr_en;
    logic               rd_en;
    logic [15:0]        rd_word;
    logic               drive_lo;
    logic               drive_hi;

    // Address decode: unsigned compare against the depth, no wrap-around.
    always_comb begin
        a_ext    = CmpBits'(A);
        in_range = (a_ext < DepthExt);
        idx      = IdxBits'(a_ext);
    end

    // Cycle qualification. A requested write always wins over output enable, so
    // the model never drives the bus while the host may be driving it. Writes
    // ignore reset; reads are suppressed by it.
    always_comb begin
        wr_en    = !CE_ && !WE_ && in_range;
        rd_en    = !CE_ && WE_ && !OE_ && !rst;
        drive_lo = rd_en && !LB_;
        drive_hi = rd_en && !UB_;
    end

    // Array read; addresses beyond the array return zero on enabled lanes.
    always_comb begin
        rd_word = 16'h0000;
        if (in_range) begin
            rd_word = mem[idx];
        end
    end

    // Byte-masked write; a disabled lane keeps its previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!LB_) begin
                mem[idx][7:0] <= IO[7:0];
            end
            if (!UB_) begin
                mem[idx][15:8] <= IO[15:8];
            end
        end
    end

    assign IO[7:0]  = drive_lo ? rd_word[7:0]  : 8'hzz;
    assign IO[15:8] = drive_hi ? rd_word[15:8] : 8'hzz;

endmodule

// File: tb/tb_is61lv6416l_sram.sv
// tb_is61lv6416l_sram: scoreboard bench for the asynchronous SRAM model.
// Both buses are pulled up, so a lane the SRAM leaves floating reads as 8'hFF.

module tb_is61lv6416l_sram;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Main instance: 64 words, 8-bit address.
    logic [7:0]  a;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;
    logic        drv;
    logic [15:0] drv_data;
    tri1  [15:0] io;

    assign io = drv ? drv_data : 16'hzzzz;

    is61lv6416l_sram #(.memdepth(64), .addbits(8)) dut (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .IO  (io),
        .CE_ (ce_n),
        .OE_ (oe_n),
        .WE_ (we_n),
        .LB_ (lb_n),
        .UB_ (ub_n)
    );

    // Small instance: 8 words behind a 4-bit address, for out-of-range access.
    logic [3:0]  s_a;
    logic        s_ce_n, s_oe_n, s_we_n, s_lb_n, s_ub_n;
    logic        s_drv;
    logic [15:0] s_drv_data;
    tri1  [15:0] s_io;

    assign s_io = s_drv ? s_drv_data : 16'hzzzz;

    is61lv6416l_sram #(.memdepth(8), .addbits(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .A   (s_a),
        .IO  (s_io),
        .CE_ (s_ce_n),
        .OE_ (s_oe_n),
        .WE_ (s_we_n),
        .LB_ (s_lb_n),
        .UB_ (s_ub_n)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    // Drive one write cycle, committed on the next rising edge.
    task automatic wr(input logic [7:0] addr, input logic [15:0] data,
                      input logic lb, input logic ub);
        @(negedge clk);
        a = addr; drv_data = data; drv = 1'b1;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; lb_n = lb; ub_n = ub;
        @(posedge clk);
        #1;
        we_n = 1'b1; drv = 1'b0; lb_n = 1'b0; ub_n = 1'b0; oe_n = 1'b0;
    endtask

    // Set up a read cycle at the next falling edge.
    task automatic rd(input logic [7:0] addr, input logic lb, input logic ub);
        @(negedge clk);
        a = addr; drv = 1'b0;
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; lb_n = lb; ub_n = ub;
    endtask

    task automatic s_wr(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        s_a = addr; s_drv_data = data; s_drv = 1'b1;
        s_ce_n = 1'b0; s_we_n = 1'b0; s_oe_n = 1'b1; s_lb_n = 1'b0; s_ub_n = 1'b0;
        @(posedge clk);
        #1;
        s_we_n = 1'b1; s_drv = 1'b0; s_ce_n = 1'b1;
    endtask

    task automatic s_rd(input logic [3:0] addr);
        @(negedge clk);
        s_a = addr; s_drv = 1'b0;
        s_ce_n = 1'b0; s_we_n = 1'b1; s_oe_n = 1'b0; s_lb_n = 1'b0; s_ub_n = 1'b0;
    endtask

    task automatic test_reset();
        // Read requested while held in reset: bus must float.
        @(negedge clk);
        a = 8'd3; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
        exp_q.push_back(16'hFFFF);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL reset_float: io=%h expected %h", io, exp_v); end

        // Preload while in reset, still floating afterwards.
        wr(8'd3, 16'h0008, 1'b0, 1'b0);
        rd(8'd3, 1'b0, 1'b0);
        exp_q.push_back(16'hFFFF);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL reset_float_after_wr: io=%h expected %h", io, exp_v); end

        // Release reset: preloaded word appears without any clock.
        rst = 1'b0;
        exp_q.push_back(16'h0008);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL preload_read: io=%h expected %h", io, exp_v); end

        // Untouched word holds its zero initial value.
        rd(8'd1, 1'b0, 1'b0);
        exp_q.push_back(16'h0000);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL init_zero: io=%h expected %h", io, exp_v); end
    endtask

    task automatic test_byte_mask();
        wr(8'd5, 16'hA0B0, 1'b0, 1'b0);
        wr(8'd5, 16'h1234, 1'b0, 1'b1);
        rd(8'd5, 1'b0, 1'b0);
        exp_q.push_back(16'hA034);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL mask_full: io=%h expected %h", io, exp_v); end

        rd(8'd5, 1'b1, 1'b0);
        exp_q.push_back(16'hA0FF);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL mask_upper_only: io=%h expected %h", io, exp_v); end

        rd(8'd5, 1'b0, 1'b1);
        exp_q.push_back(16'hFF34);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL mask_lower_only: io=%h expected %h", io, exp_v); end
    endtask

    task automatic test_output_gating();
        wr(8'd6, 16'hC0D0, 1'b0, 1'b0);
        rd(8'd6, 1'b0, 1'b0);
        exp_q.push_back(16'hC0D0);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL gate_base: io=%h expected %h", io, exp_v); end

        // Chip deselected, with a write attempted across an edge.
        @(negedge clk);
        ce_n = 1'b1;
        exp_q.push_back(16'hFFFF);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL gate_ce: io=%h expected %h", io, exp_v); end
        we_n = 1'b0; drv_data = 16'h1111; drv = 1'b1;
        @(posedge clk);
        #1;
        we_n = 1'b1; drv = 1'b0; ce_n = 1'b0;
        exp_q.push_back(16'hC0D0);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL gate_ce_nowrite: io=%h expected %h", io, exp_v); end

        @(negedge clk);
        oe_n = 1'b1;
        exp_q.push_back(16'hFFFF);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL gate_oe: io=%h expected %h", io, exp_v); end
        @(posedge clk);
        #1;
        oe_n = 1'b0;
        exp_q.push_back(16'hC0D0);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL gate_oe_nowrite: io=%h expected %h", io, exp_v); end

        // Write request with OE_ low: write wins, bus floats. Released before the edge.
        @(negedge clk);
        we_n = 1'b0;
        exp_q.push_back(16'hFFFF);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL gate_we: io=%h expected %h", io, exp_v); end
        we_n = 1'b1;
    endtask

    task automatic test_reset_tristate();
        wr(8'd7, 16'h7600, 1'b0, 1'b0);
        rd(8'd7, 1'b0, 1'b0);
        exp_q.push_back(16'h7600);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL rst_pre: io=%h expected %h", io, exp_v); end
        #1 rst = 1'b1;
        exp_q.push_back(16'hFFFF);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL rst_async_float: io=%h expected %h", io, exp_v); end
        rst = 1'b0;
        exp_q.push_back(16'h7600);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL rst_release: io=%h expected %h", io, exp_v); end
    endtask

    task automatic test_out_of_range();
        s_wr(4'd4, 16'h1111);
        s_wr(4'd12, 16'hFFFF);
        s_rd(4'd12);
        exp_q.push_back(16'h0000);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (s_io !== exp_v) begin n_fail++; $display("FAIL oor_read: io=%h expected %h", s_io, exp_v); end
        s_rd(4'd4);
        exp_q.push_back(16'h1111);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (s_io !== exp_v) begin n_fail++; $display("FAIL oor_no_wrap: io=%h expected %h", s_io, exp_v); end
        s_ce_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        wr(8'h28, 16'h33C0, 1'b0, 1'b0);
        rd(8'h28, 1'b0, 1'b0);
        exp_q.push_back(16'h33C0);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL b2b_read_after_write: io=%h expected %h", io, exp_v); end

        // Consecutive edges to the same word: last write wins.
        wr(8'h28, 16'h9999, 1'b0, 1'b0);
        wr(8'h28, 16'h5240, 1'b0, 1'b0);
        rd(8'h28, 1'b0, 1'b0);
        exp_q.push_back(16'h5240);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL b2b_last_wins: io=%h expected %h", io, exp_v); end

        // Lower-only then upper-only on consecutive edges merge.
        wr(8'h29, 16'h0077, 1'b0, 1'b1);
        wr(8'h29, 16'h8800, 1'b1, 1'b0);
        rd(8'h29, 1'b0, 1'b0);
        exp_q.push_back(16'h8877);
        #1; exp_v = exp_q.pop_front(); n_checks++;
        if (io !== exp_v) begin n_fail++; $display("FAIL b2b_merge: io=%h expected %h", io, exp_v); end
    endtask

    initial begin
        rst = 1'b1;
        a = 8'd0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
        drv = 1'b0; drv_data = 16'h0000;
        s_a = 4'd0; s_ce_n = 1'b1; s_oe_n = 1'b1; s_we_n = 1'b1; s_lb_n = 1'b0; s_ub_n = 1'b0;
        s_drv = 1'b0; s_drv_data = 16'h0000;

        test_reset();
        test_byte_mask();
        test_output_gating();
        test_reset_tristate();
        test_out_of_range();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/is61lv6416l_sram.md
# is61lv6416l_sram

Behavioural/synthesizable model of a 16-bit-wide asynchronous SRAM in the IS61LV6416L style, with independent upper/lower byte enables and a shared bidirectional data bus. It is the main-memory target for the CPU bench: the CPU address bus drives `A`, and the bench preloads firmware through the same pins. Reads are combinational. Writes commit on the rising edge of `clk`, which makes the model cycle-exact in the clocked bench environment.

## Interface
Parameters:
- `memdepth`, default 65536: number of 16-bit words in the array (the bench uses 262144).
- `addbits`, default 16: width of the address bus `A` (the bench uses 18).

Ports:
- `clk`  in  1  clock; rising edge commits writes.
- `rst`  in  1  reset, asynchronous, active-high; forces `IO` to high-Z while asserted (see Operation).
- `A`  in  addbits  word address.
- `IO`  inout  16  data bus; `IO[15:8]` is the upper byte, `IO[7:0]` the lower byte.
- `CE_`  in  1  chip enable, active low.
- `OE_`  in  1  output enable, active low.
- `WE_`  in  1  write enable, active low.
- `LB_`  in  1  lower byte enable, active low, gates `IO[7:0]`.
- `UB_`  in  1  upper byte enable, active low, gates `IO[15:8]`.

## Operation
- Array: `memdepth` × 16-bit words, all initialised to 16'h0000 at time zero.
- The array is never cleared by `rst`. The bench loads firmware while `rst`=1, so writes remain fully functional during reset.
- **Write cycle:** `CE_`=0 and `WE_`=0 at a rising `clk` edge with `A` < `memdepth`.
  - If `LB_`=0, write `IO[7:0]` to `mem[A][7:0]`.
  - If `UB_`=0, write `IO[15:8]` to `mem[A][15:8]`.
  - A byte whose enable is 1 keeps its old value.
  - `OE_` is ignored during a write.
  - Writes to `A` ≥ `memdepth` are discarded.
- **Read cycle:** the read is active when `CE_`=0, `WE_`=1, `OE_`=0 and `rst`=0.
  - `IO[7:0]` = `mem[A][7:0]` if `LB_`=0, otherwise Z.
  - `IO[15:8]` = `mem[A][15:8]` if `UB_`=0, otherwise Z.
  - `A` ≥ `memdepth` reads 16'h0000 on the enabled lanes.
- **All other cases:** `IO` is fully high-Z. This includes `CE_`=1, `WE_`=0, `OE_`=1, and `rst`=1.
- **Bus contention:** `WE_`=0 always wins over `OE_`=0, so the model never drives `IO` while a write is requested.
- `A` is treated as unsigned. There is no address wrap-around.

## Timing
- **Read:** combinational, zero delay from `A`, `CE_`, `OE_`, `WE_`, `LB_`, `UB_` and `rst` to `IO`.
- **Write:** data, address and byte enables are sampled at the rising `clk` edge.
  - The new contents are visible on a read in the same timestep after the edge.
  - A read issued in the cycle following a write to the same address returns the written data.
- **Reset:** asserting `rst` asynchronously tri-states `IO` immediately. Deasserting `rst` restores driving on the next evaluation, with no clock needed.
- **Write collisions:** two writes to the same address on consecutive edges resolve as last-write-wins. A byte-masked write followed by a write to the other byte merges the two.
- **Reset mid-write:** a write edge while `rst`=1 still commits.

## Test plan
- **Preload during reset.** With `rst`=1, write `A`=3 ← 16'h0008 (`CE_`=0, `WE_`=0, `LB_`=`UB_`=0). Then set `rst`=0, `WE_`=1, `OE_`=0, `A`=3 → `IO`=16'h0008.
- **Byte masking.** Write `A`=5 ← 16'hA0B0 with both lanes. Then write `A`=5 ← 16'h1234 with `LB_`=0, `UB_`=1. Full read → 16'hA034. Read with `UB_`=0, `LB_`=1 → `IO`=16'hA0ZZ.
- **Output gating.** After a valid read of 16'hC0D0 at `A`=6, each of `CE_`=1, `OE_`=1 and `WE_`=0 (tested one at a time) → `IO`=Z on all 16 bits, and no write occurs in the `CE_`=1 and `OE_`=1 cases.
- **Reset tri-state.** During an active read of 16'h7600, assert `rst` asynchronously mid-cycle → `IO` goes to Z immediately. Release `rst` → `IO`=16'h7600 again.
- **Out of range.** With `memdepth`=8 and `addbits`=4, write `A`=12 ← 16'hFFFF, then read `A`=12 → 16'h0000. `mem[4]` is unchanged (no wrap).
- **Back-to-back.** Write `A`=0x28 ← 16'h33C0, then read `A`=0x28 on the next cycle → 16'h33C0. Write `A`=0x28 ← 16'h5240 on two consecutive edges, then read → 16'h5240.
